fetch_stage: RTL and testbench

Instruction fetch stage and IF/ID pipeline register that sits directly upstream of the control unit. It owns the program counter and issues word reads to instruction memory under a req/valid handshake. It holds the fetched word in a stall-able IF/ID register and slices it into the cond/op/funct/sh and register fields the control unit consumes. It honours branch redirects (`sel_PC`), squashing the wrong-path word and any fetch still in flight.

---
 rtl/imem_if.sv | 20 ++
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_if.sv
// Instruction-memory read channel between the fetch stage and memory.
// One outstanding request; the master holds req/addr until valid.
interface imem_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_valid;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_valid
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC, imem request FSM, skid buffer and IF/ID register.
// Redirects squash the IF/ID word, the skid word and any fetch in flight.
module fetch_stage #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  imem_if.master            imem,
  input  logic              stall,
  input  logic              sel_PC,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [3:0]        cond,
  output logic [1:0]        op,
  output logic [5:0]        funct,
  output logic [3:0]        rn,
  output logic [3:0]        rd,
  output logic [1:0]        sh,
  output logic [3:0]        rm,
  output logic [23:0]       imm24
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DROP
  } state_t;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } if_id_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] drop_addr, drop_addr_n;
  logic [ADDR_W-1:0] tgt;
  if_id_t            skid, skid_n;
  logic              iv_n;
  logic [31:0]       instr_n;
  logic [ADDR_W-1:0] pc_out_n;
  logic              slot_free;
  logic              unused_tgt_bits;

  assign tgt = {branch_target[ADDR_W-1:2], 2'b00};
  assign unused_tgt_bits = ^branch_target[1:0];
  assign slot_free = !instr_valid || !stall;

  assign imem.imem_req = (state == FETCH) || (state == DROP);
  assign imem.imem_addr = (state == DROP) ? drop_addr : pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drop_addr   <= RESET_PC;
      skid        <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      pc_out      <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      drop_addr   <= drop_addr_n;
      skid        <= skid_n;
      instr_valid <= iv_n;
      instr       <= instr_n;
      pc_out      <= pc_out_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    drop_addr_n = drop_addr;
    skid_n      = skid;
    iv_n        = instr_valid;
    instr_n     = instr;
    pc_out_n    = pc_out;
    unique case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (imem.imem_valid) begin
          pc_n = pc + ADDR_W'(4);
          if (slot_free) begin
            instr_n  = imem.imem_rdata;
            pc_out_n = pc;
            iv_n     = 1'b1;
          end else begin
            skid_n  = '{instr: imem.imem_rdata, pc: pc};
            state_n = HOLD;
          end
        end else if (slot_free) begin
          iv_n = 1'b0;
        end
      end
      HOLD: begin
        if (!stall) begin
          instr_n  = skid.instr;
          pc_out_n = skid.pc;
          iv_n     = 1'b1;
          state_n  = FETCH;
        end
      end
      DROP: begin
        if (imem.imem_valid) state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
    // Redirect overrides everything decided above
    if (sel_PC) begin
      pc_n     = tgt;
      iv_n     = 1'b0;
      instr_n  = instr;
      pc_out_n = pc_out;
      skid_n   = skid;
      unique case (state)
        IDLE: state_n = FETCH;
        HOLD: state_n = FETCH;
        FETCH: begin
          state_n = imem.imem_valid ? FETCH : DROP;
          if (!imem.imem_valid) drop_addr_n = pc;
        end
        DROP: state_n = imem.imem_valid ? FETCH : DROP;
        default: state_n = IDLE;
      endcase
    end
  end

  assign cond  = instr[31:28];
  assign op    = instr[27:26];
  assign funct = instr[25:20];
  assign rn    = instr[19:16];
  assign rd    = instr[15:12];
  assign sh    = instr[6:5];
  assign rm    = instr[3:0];
  assign imm24 = instr[23:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: wait states, stall/skid, redirect,
// field slicing, PC wrap and reset mid-request.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        sel_PC = 1'b0;
  logic [31:0] branch_target = '0;

  int total = 0;
  int bad = 0;
  int mem_wait = 0;
  int wcnt;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [1:0]  sh;
    logic [3:0]  rm;
    logic [23:0] imm24;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  imem_if #(.ADDR_W(32)) m1 ();
  imem_if #(.ADDR_W(32)) m2 ();

  logic        iv, d2_iv;
  logic [31:0] instr, d2_instr, pc_out, d2_pc_out;
  logic [3:0]  cond, rn, rd, rm, d2_cond, d2_rn, d2_rd, d2_rm;
  logic [1:0]  op, sh, d2_op, d2_sh;
  logic [5:0]  funct, d2_funct;
  logic [23:0] imm24, d2_imm24;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem(m1.master),
    .stall(stall), .sel_PC(sel_PC), .branch_target(branch_target),
    .instr_valid(iv), .instr(instr), .pc_out(pc_out),
    .cond(cond), .op(op), .funct(funct), .rn(rn), .rd(rd),
    .sh(sh), .rm(rm), .imm24(imm24)
  );

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .imem(m2.master),
    .stall(1'b0), .sel_PC(1'b0), .branch_target(32'h0),
    .instr_valid(d2_iv), .instr(d2_instr), .pc_out(d2_pc_out),
    .cond(d2_cond), .op(d2_op), .funct(d2_funct), .rn(d2_rn),
    .rd(d2_rd), .sh(d2_sh), .rm(d2_rm), .imm24(d2_imm24)
  );

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a[31:8] == 24'h2 && a[7:2] < 6) return tbl[a[7:2]].word;
    return a;
  endfunction

  assign m1.imem_valid = m1.imem_req && (wcnt == mem_wait);
  assign m1.imem_rdata = m1.imem_valid ? mem_word(m1.imem_addr)
                                       : 32'hDEAD_BEEF;
  assign m2.imem_valid = m2.imem_req;
  assign m2.imem_rdata = m2.imem_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (m1.imem_req && !m1.imem_valid) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int w);
    rst = 1'b1;
    stall = 1'b0;
    sel_PC = 1'b0;
    mem_wait = w;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'hE281_2005, 4'hE, 2'd0, 6'h28, 4'h1, 4'h2, 2'd0, 4'h5, 24'h812005};
    tbl[1] = '{32'h0000_0000, 4'h0, 2'd0, 6'h00, 4'h0, 4'h0, 2'd0, 4'h0, 24'h000000};
    tbl[2] = '{32'hFFFF_FFFF, 4'hF, 2'd3, 6'h3F, 4'hF, 4'hF, 2'd3, 4'hF, 24'hFFFFFF};
    tbl[3] = '{32'hE59F_1064, 4'hE, 2'd1, 6'h19, 4'hF, 4'h1, 2'd3, 4'h4, 24'h9F1064};
    tbl[4] = '{32'h1A00_0060, 4'h1, 2'd2, 6'h20, 4'h0, 4'h0, 2'd3, 4'h0, 24'h000060};
    tbl[5] = '{32'h0AB3_C0C7, 4'h0, 2'd2, 6'h2B, 4'h3, 4'hC, 2'd2, 4'h7, 24'hB3C0C7};

    // reset values
    rst = 1'b1;
    step();
    step();
    chk("rst_iv", 32'(iv), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_req", 32'(m1.imem_req), 0);
    chk("rst_addr", m1.imem_addr, 0);
    chk("rst_cond", 32'(cond), 0);
    chk("rst_imm24", 32'(imm24), 0);
    chk("rst_addr2", m2.imem_addr, 32'hFFFF_FFF8);
    chk("rst_req2", 32'(m2.imem_req), 0);

    // zero-wait sequential fetch, plus wrap on dut2
    do_reset(0);
    step();
    chk("seq_e1_req", 32'(m1.imem_req), 1);
    chk("seq_e1_addr", m1.imem_addr, 0);
    chk("seq_e1_iv", 32'(iv), 0);
    chk("wrap_e1_addr", m2.imem_addr, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("seq_iv", 32'(iv), 1);
      chk("seq_instr", instr, 32'(4 * i));
      chk("seq_pc_out", pc_out, 32'(4 * i));
      chk("seq_addr", m1.imem_addr, 32'(4 * (i + 1)));
      if (i < 3) begin
        chk("wrap_pc_out", d2_pc_out, 32'hFFFF_FFF8 + 32'(4 * i));
        chk("wrap_instr", d2_instr, 32'hFFFF_FFF8 + 32'(4 * i));
        chk("wrap_addr", m2.imem_addr, 32'hFFFF_FFFC + 32'(4 * i));
      end
    end

    // 3-cycle wait memory
    do_reset(2);
    step();
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 3; k++) begin
        chk("wait_req", 32'(m1.imem_req), 1);
        chk("wait_addr", m1.imem_addr, 32'(4 * w));
        chk("wait_iv", 32'(iv), 32'((w > 0) && (k == 0)));
        step();
      end
    end
    chk("wait_iv_8", 32'(iv), 1);
    chk("wait_instr_8", instr, 32'h8);
    chk("wait_pc_8", pc_out, 32'h8);
    chk("wait_next_addr", m1.imem_addr, 32'hC);

    // stall for 4 cycles while a response lands in the skid buffer
    do_reset(0);
    step();
    step();
    chk("stall_pre_instr", instr, 0);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_req", 32'(m1.imem_req), 0);
      chk("stall_instr", instr, 0);
      chk("stall_pc_out", pc_out, 0);
      chk("stall_iv", 32'(iv), 1);
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("skid_iv", 32'(iv), 1);
      chk("skid_instr", instr, 32'(4 * (i + 1)));
    end

    // redirect while a 2-wait request to 0x20 is pending
    do_reset(0);
    step();
    repeat (8) step();
    chk("br_addr_20", m1.imem_addr, 32'h20);
    mem_wait = 2;
    step();
    chk("br_pend_req", 32'(m1.imem_req), 1);
    sel_PC = 1'b1;
    branch_target = 32'h103;
    step();
    sel_PC = 1'b0;
    chk("drop_req", 32'(m1.imem_req), 1);
    chk("drop_addr", m1.imem_addr, 32'h20);
    chk("drop_iv", 32'(iv), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("tgt_req", 32'(m1.imem_req), 1);
      chk("tgt_addr", m1.imem_addr, 32'h100);
      chk("tgt_iv", 32'(iv), 0);
    end
    step();
    chk("tgt_load_iv", 32'(iv), 1);
    chk("tgt_load_instr", instr, 32'h100);
    chk("tgt_load_pc", pc_out, 32'h100);

    // field slicing table, entered via a redirect with a live response
    do_reset(0);
    step();
    sel_PC = 1'b1;
    branch_target = 32'h200;
    step();
    sel_PC = 1'b0;
    chk("fld_br_iv", 32'(iv), 0);
    chk("fld_br_addr", m1.imem_addr, 32'h200);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fld_iv", 32'(iv), 1);
      chk("fld_pc", pc_out, 32'h200 + 32'(4 * i));
      chk("fld_instr", instr, tbl[i].word);
      chk("fld_cond", 32'(cond), 32'(tbl[i].cond));
      chk("fld_op", 32'(op), 32'(tbl[i].op));
      chk("fld_funct", 32'(funct), 32'(tbl[i].funct));
      chk("fld_rn", 32'(rn), 32'(tbl[i].rn));
      chk("fld_rd", 32'(rd), 32'(tbl[i].rd));
      chk("fld_sh", 32'(sh), 32'(tbl[i].sh));
      chk("fld_rm", 32'(rm), 32'(tbl[i].rm));
      chk("fld_imm24", 32'(imm24), 32'(tbl[i].imm24));
    end

    // reset asserted in the middle of a waited request
    do_reset(0);
    step();
    repeat (3) step();
    chk("mid_pre_instr", instr, 32'h8);
    mem_wait = 3;
    step();
    chk("mid_req", 32'(m1.imem_req), 1);
    chk("mid_addr", m1.imem_addr, 32'hC);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(m1.imem_req), 0);
    chk("mid_rst_addr", m1.imem_addr, 0);
    chk("mid_rst_iv", 32'(iv), 0);
    chk("mid_rst_instr", instr, 0);
    chk("mid_rst_pc_out", pc_out, 0);
    chk("mid_rst_rm", 32'(rm), 0);
    chk("mid_rst_addr2", m2.imem_addr, 32'hFFFF_FFF8);
    chk("mid_rst_iv2", 32'(d2_iv), 0);
    step();
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
